brush_writer: RTL and testbench
===============================

# brush_writer

Write-side front end for the 128×128 pixel store. Accepts brush stroke and clear-screen commands from the input/control logic and expands each into a sequence of single-pixel write requests (coordinate + color code) into the pixel store's write port. Clips brush footprints to the 128×128 canvas and honors a stall input so writes land only in the store's write slots; the VGA read side is untouched.

## Interface
Parameters:
- COORD_W, 7, bits per canvas coordinate; canvas is 2^COORD_W square (128)
- COLOR_W, 3, color code width; matches the pixel store color codes
- SIZE_W, 3, brush half-width field width; max half-width 7

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset; asserted when 0
- cmdValid  input  1  command present; held stable until accepted
- cmdReady  output  1  block can accept a command; high exactly when idle
- cmdClear  input  1  1 = clear entire canvas, 0 = brush stroke
- cmdX, cmdY  input  COORD_W  brush center; ignored for clear
- cmdSize  input  SIZE_W  brush half-width h; footprint (2h+1)×(2h+1)
- cmdColor  input  COLOR_W  color written to every pixel of the command
- wrEn  output  1  write request valid
- wrX, wrY  output  COORD_W  pixel to write
- wrColor  output  COLOR_W  color to write
- wrStall  input  1  store cannot take a write this cycle
- busy  output  1  command in progress
- doneStrobe  output  1  one-cycle pulse on command completion

## Operation
- States: IDLE, PAINT, CLEAR. Reset forces IDLE.
- Command accepted on a rising edge with cmdValid=1 and state IDLE. All command fields are latched on acceptance; later changes to them are ignored.
- Brush bounds are computed at acceptance with COORD_W+2-bit signed arithmetic. xLo = max(cmdX−h, 0) and xHi = min(cmdX+h, 127); y bounds are computed the same way. IDLE→PAINT.
- PAINT: iterate row-major, x fastest, starting at (xLo, yLo). After (xHi, y) comes (xLo, y+1). The last write is (xHi, yHi). Clipped pixels are never emitted and cost no cycles.
- Clear: IDLE→CLEAR. Iterate (0,0)…(127,0),(0,1)…(127,127) with the latched color. Exactly 16384 writes.
- A write is consumed on an edge with wrEn=1 and wrStall=0. With wrStall=1, wrX, wrY, wrColor and wrEn hold unchanged.
- When the last write is consumed, state returns to IDLE. doneStrobe=1 for the first IDLE cycle only.
- cmdValid while busy: not accepted. cmdReady=0 and the initiator holds the command.
- h=0 yields exactly one write at (cmdX, cmdY).
- Reset mid-command: wrEn, busy and doneStrobe fall immediately (asynchronously). The command is abandoned and no completion pulse is produced.

## Timing
- Reset values: wrEn=0, wrX=0, wrY=0, wrColor=0, busy=0, doneStrobe=0, cmdReady=1.
- Acceptance at edge N. wrEn=1 and the first coordinate appear from cycle N+1. busy=1 from N+1.
- With no stalls, one write per cycle. A W×H clipped footprint completes in W·H cycles. Last write consumed at edge N+W·H. doneStrobe=1, cmdReady=1 and busy=0 in cycle N+W·H+1.
- Each stall cycle extends the sequence by exactly one cycle.
- A new command may be accepted in the same cycle doneStrobe is high. Back-to-back commands therefore have one idle cycle between write bursts.
- wrEn is registered; no combinational path from cmdValid or wrStall to write outputs, except that the held values under stall come from registers.

## Test plan
- Reset: hold reset=0 for 3 cycles → wrEn=0, busy=0, doneStrobe=0, cmdReady=1, wrX/wrY/wrColor=0.
- Stroke (10,20), h=1, color 3'b010, no stall → 9 writes (9,19),(10,19),(11,19),(9,20)…(11,21) on cycles N+1..N+9. doneStrobe only at N+10.
- Clipping: (0,0) h=2 → 9 writes over x,y∈{0,1,2}. Then (127,127) h=1 → 4 writes (126,126),(127,126),(126,127),(127,127).
- Stall: stroke (10,20) h=1 with wrStall toggling 1,0,1,0… → identical 9-write sequence, each coordinate held until consumed. Total 18 cycles. cmdValid pulsed mid-burst is not accepted.
- Clear, color 3'b000 → 16384 writes, first (0,0), last (127,127). doneStrobe at N+16385.
- Reset asserted at the 4th write of an h=2 stroke → wrEn drops same cycle. After release, cmdReady=1, no doneStrobe, and the next command starts cleanly.

Source files
------------

// File: rtl/brush_writer_if.sv
// Command and pixel-write bus between the control logic, brush_writer and the pixel store.
// The slave modport is the brush_writer side.
interface brush_writer_if #(
  parameter int unsigned COORD_W = 7,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned SIZE_W  = 3
);
  logic               cmdValid;
  logic               cmdReady;
  logic               cmdClear;
  logic [COORD_W-1:0] cmdX;
  logic [COORD_W-1:0] cmdY;
  logic [SIZE_W-1:0]  cmdSize;
  logic [COLOR_W-1:0] cmdColor;
  logic               wrEn;
  logic [COORD_W-1:0] wrX;
  logic [COORD_W-1:0] wrY;
  logic [COLOR_W-1:0] wrColor;
  logic               wrStall;
  logic               busy;
  logic               doneStrobe;

  modport master (
    output cmdValid, cmdClear, cmdX, cmdY, cmdSize, cmdColor, wrStall,
    input  cmdReady, wrEn, wrX, wrY, wrColor, busy, doneStrobe
  );

  modport slave (
    input  cmdValid, cmdClear, cmdX, cmdY, cmdSize, cmdColor, wrStall,
    output cmdReady, wrEn, wrX, wrY, wrColor, busy, doneStrobe
  );
endinterface

// File: rtl/brush_writer.sv
// Expands brush-stroke and clear-screen commands into single-pixel writes for the
// pixel store, clipping brush footprints to the canvas and honouring write stalls.
module brush_writer #(
  parameter int unsigned COORD_W = 7,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned SIZE_W  = 3
) (
  input logic           clk,
  input logic           reset,
  brush_writer_if.slave bus
);

  localparam int unsigned SW = COORD_W + 2;
  localparam logic signed [SW-1:0] MaxS = $signed({2'b00, {COORD_W{1'b1}}});
  localparam logic [COORD_W-1:0] One = {{(COORD_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StPaint, StClear} state_e;

  state_e             state_q;
  logic [COORD_W-1:0] x_q, y_q, xlo_q, xhi_q, yhi_q;
  logic [COLOR_W-1:0] color_q;
  logic               wr_en_q, busy_q, done_q;

  logic signed [SW-1:0] cx_s, cy_s, h_s;
  logic [COORD_W-1:0]   xlo_c, xhi_c, ylo_c, yhi_c;

  function automatic logic [COORD_W-1:0] clip(input logic signed [SW-1:0] v);
    if (v[SW-1]) begin
      return '0;
    end else if (v > MaxS) begin
      return '1;
    end else begin
      return v[COORD_W-1:0];
    end
  endfunction

  // Footprint bounds from the live command fields; only sampled on acceptance.
  always_comb begin
    cx_s  = $signed({2'b00, bus.cmdX});
    cy_s  = $signed({2'b00, bus.cmdY});
    h_s   = $signed({{(SW-SIZE_W){1'b0}}, bus.cmdSize});
    xlo_c = clip(cx_s - h_s);
    xhi_c = clip(cx_s + h_s);
    ylo_c = clip(cy_s - h_s);
    yhi_c = clip(cy_s + h_s);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      xlo_q   <= '0;
      xhi_q   <= '0;
      yhi_q   <= '0;
      color_q <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.cmdValid) begin
            color_q <= bus.cmdColor;
            wr_en_q <= 1'b1;
            busy_q  <= 1'b1;
            if (bus.cmdClear) begin
              x_q     <= '0;
              y_q     <= '0;
              xlo_q   <= '0;
              xhi_q   <= '1;
              yhi_q   <= '1;
              state_q <= StClear;
            end else begin
              x_q     <= xlo_c;
              y_q     <= ylo_c;
              xlo_q   <= xlo_c;
              xhi_q   <= xhi_c;
              yhi_q   <= yhi_c;
              state_q <= StPaint;
            end
          end
        end
        StPaint, StClear: begin
          // Outputs advance only when the current write is consumed.
          if (!bus.wrStall) begin
            if (x_q == xhi_q) begin
              if (y_q == yhi_q) begin
                wr_en_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StIdle;
              end else begin
                x_q <= xlo_q;
                y_q <= y_q + One;
              end
            end else begin
              x_q <= x_q + One;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmdReady   = (state_q == StIdle);
  assign bus.wrEn       = wr_en_q;
  assign bus.wrX        = x_q;
  assign bus.wrY        = y_q;
  assign bus.wrColor    = color_q;
  assign bus.busy       = busy_q;
  assign bus.doneStrobe = done_q;

endmodule

// File: tb/tb_brush_writer.sv
// Directed bench for brush_writer: table of commands with hand-computed clipped bounds
// and cycle counts, plus reset, stall and mid-command reset sequences.
module tb_brush_writer;

  typedef struct {
    logic clr;
    int   x, y, h, color;
    logic stall;
    int   xlo, xhi, ylo, yhi;
    int   cycles;
  } vec_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  vec_t vecs[7];
  vec_t rv;

  brush_writer_if #(.COORD_W(7), .COLOR_W(3), .SIZE_W(3)) bus ();

  brush_writer #(.COORD_W(7), .COLOR_W(3), .SIZE_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input vec_t v);
    int w, n, idx, cyc, wait_c;
    w = v.xhi - v.xlo + 1;
    n = w * (v.yhi - v.ylo + 1);
    wait_c = 0;
    while (bus.cmdReady !== 1'b1 && wait_c < 20) begin
      tick();
      wait_c++;
    end
    chk("ready_before_cmd", int'(bus.cmdReady), 1);
    bus.cmdValid = 1'b1;
    bus.cmdClear = v.clr;
    bus.cmdX     = 7'(v.x);
    bus.cmdY     = 7'(v.y);
    bus.cmdSize  = 3'(v.h);
    bus.cmdColor = 3'(v.color);
    bus.wrStall  = 1'b0;
    tick();
    // Scramble fields after acceptance; the DUT must use its latched copy.
    bus.cmdValid = 1'b0;
    bus.cmdClear = ~v.clr;
    bus.cmdX     = 7'(v.x ^ 85);
    bus.cmdY     = 7'(v.y ^ 42);
    bus.cmdSize  = 3'(v.h ^ 5);
    bus.cmdColor = 3'(~v.color);
    idx = 0;
    cyc = 1;
    while (idx < n && cyc <= v.cycles + 50) begin
      bus.wrStall = v.stall ? (cyc % 2 == 1) : 1'b0;
      if (v.stall && cyc == 4) begin
        bus.cmdValid = 1'b1;
        bus.cmdClear = 1'b0;
        bus.cmdX     = 7'd0;
        bus.cmdY     = 7'd0;
        chk("ready_midburst", int'(bus.cmdReady), 0);
      end else begin
        bus.cmdValid = 1'b0;
      end
      chk("wrEn", int'(bus.wrEn), 1);
      chk("busy", int'(bus.busy), 1);
      chk("done_early", int'(bus.doneStrobe), 0);
      chk("wrX", int'(bus.wrX), v.xlo + idx % w);
      chk("wrY", int'(bus.wrY), v.ylo + idx / w);
      chk("wrColor", int'(bus.wrColor), v.color);
      if (!bus.wrStall) idx++;
      tick();
      cyc++;
    end
    bus.wrStall  = 1'b0;
    bus.cmdValid = 1'b0;
    chk("writes", idx, n);
    chk("cycles", cyc - 1, v.cycles);
    chk("done", int'(bus.doneStrobe), 1);
    chk("busy_end", int'(bus.busy), 0);
    chk("ready_end", int'(bus.cmdReady), 1);
    chk("wrEn_end", int'(bus.wrEn), 0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    vecs[0] = '{1'b0, 10, 20, 1, 2, 1'b0, 9, 11, 19, 21, 9};
    vecs[1] = '{1'b0, 0, 0, 2, 5, 1'b0, 0, 2, 0, 2, 9};
    vecs[2] = '{1'b0, 127, 127, 1, 7, 1'b0, 126, 127, 126, 127, 4};
    vecs[3] = '{1'b0, 10, 20, 1, 2, 1'b1, 9, 11, 19, 21, 18};
    vecs[4] = '{1'b0, 64, 5, 0, 1, 1'b0, 64, 64, 5, 5, 1};
    vecs[5] = '{1'b0, 3, 125, 7, 6, 1'b0, 0, 10, 118, 127, 110};
    vecs[6] = '{1'b1, 33, 44, 3, 0, 1'b0, 0, 127, 0, 127, 16384};

    reset        = 1'b0;
    bus.cmdValid = 1'b0;
    bus.cmdClear = 1'b0;
    bus.cmdX     = '0;
    bus.cmdY     = '0;
    bus.cmdSize  = '0;
    bus.cmdColor = '0;
    bus.wrStall  = 1'b0;
    repeat (3) tick();
    chk("rst_wrEn", int'(bus.wrEn), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.doneStrobe), 0);
    chk("rst_ready", int'(bus.cmdReady), 1);
    chk("rst_wrX", int'(bus.wrX), 0);
    chk("rst_wrY", int'(bus.wrY), 0);
    chk("rst_wrColor", int'(bus.wrColor), 0);
    reset = 1'b1;
    tick();

    // Back-to-back: each command is issued in the previous one's done cycle.
    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i]);
    end
    tick();
    chk("done_one_cycle", int'(bus.doneStrobe), 0);

    // Reset while the 4th write of an h=2 stroke is on the bus.
    rv = '{1'b0, 50, 50, 2, 4, 1'b0, 48, 52, 48, 52, 25};
    bus.cmdValid = 1'b1;
    bus.cmdClear = 1'b0;
    bus.cmdX     = 7'd50;
    bus.cmdY     = 7'd50;
    bus.cmdSize  = 3'd2;
    bus.cmdColor = 3'd4;
    tick();
    bus.cmdValid = 1'b0;
    repeat (3) tick();
    chk("rst4_wrEn", int'(bus.wrEn), 1);
    chk("rst4_wrX", int'(bus.wrX), 51);
    chk("rst4_wrY", int'(bus.wrY), 48);
    #2 reset = 1'b0;
    #1;
    chk("async_wrEn", int'(bus.wrEn), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_done", int'(bus.doneStrobe), 0);
    chk("async_ready", int'(bus.cmdReady), 1);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_done", int'(bus.doneStrobe), 0);
      chk("post_rst_ready", int'(bus.cmdReady), 1);
      chk("post_rst_wrEn", int'(bus.wrEn), 0);
    end
    run_cmd(vecs[0]);
    run_cmd(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
